// File: rtl/mem_responder_if.sv
// Core/loader bus between the 6502 core, the byte loader and mem_responder.
// master = core + loader side, slave = memory responder.
interface mem_responder_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic [AW-1:0] address;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          cpu_resetn;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_reload;
    logic [AW-1:0] ld_count;
    logic          ld_err;
    logic          running;

    modport master (
        output address, wr_en, wr_data, ld_valid, ld_addr, ld_data, ld_last, ld_reload,
        input  rd_data, cpu_resetn, ld_ready, ld_count, ld_err, running
    );

    modport slave (
        input  address, wr_en, wr_data, ld_valid, ld_addr, ld_data, ld_last, ld_reload,
        output rd_data, cpu_resetn, ld_ready, ld_count, ld_err, running
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the 6502 core: RAM + vector file with zero-latency reads,
// plus a byte loader that fills memory while holding the core in reset.
module mem_responder #(
    parameter int unsigned RAM_AW         = 12,
    parameter logic [15:0] RESET_VECTOR   = 16'h0200,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
    localparam int unsigned CW        = 16;
    localparam logic [15:0] VEC_BASE  = 16'hFFFA;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic [15:0]   ld_count_q, ld_count_d;
    logic          ld_err_q, ld_err_d;
    logic          cpu_resetn_q, cpu_resetn_d;
    logic          ld_ready_q, ld_ready_d;
    logic          running_q, running_d;

    logic [7:0]    ram_q [RAM_DEPTH];
    logic [7:0]    vec_q [6];

    logic          xfer_c;
    logic          we_c;
    logic [15:0]   waddr_c;
    logic [7:0]    wdata_c;

    function automatic logic is_ram(input logic [15:0] a);
        return (a >> RAM_AW) == 16'h0000;
    endfunction

    function automatic logic is_vec(input logic [15:0] a);
        return a >= VEC_BASE;
    endfunction

    // Zero-latency read decode; unmapped space reads as $FF
    always_comb begin
        bus.rd_data = 8'hFF;
        if (is_ram(bus.address)) begin
            bus.rd_data = ram_q[RAM_AW'(bus.address)];
        end else if (is_vec(bus.address)) begin
            bus.rd_data = vec_q[3'(bus.address - VEC_BASE)];
        end
    end

    assign xfer_c = bus.ld_valid & ld_ready_q;

    // Next-state, loader bookkeeping and shared write-port selection
    always_comb begin
        state_d    = state_q;
        rel_cnt_d  = rel_cnt_q;
        ld_count_d = ld_count_q;
        ld_err_d   = ld_err_q;
        we_c       = 1'b0;
        waddr_c    = bus.address;
        wdata_c    = bus.wr_data;

        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                if (xfer_c) begin
                    we_c    = 1'b1;
                    waddr_c = bus.ld_addr;
                    wdata_c = bus.ld_data;
                    if (ld_count_q != 16'hFFFF) ld_count_d = ld_count_q + 16'd1;
                    if (!is_ram(bus.ld_addr) && !is_vec(bus.ld_addr)) ld_err_d = 1'b1;
                    if (bus.ld_last) begin
                        state_d   = S_RELEASE;
                        rel_cnt_d = CW'(RELEASE_CYCLES);
                    end
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q <= CW'(1)) state_d = S_RUN;
                else rel_cnt_d = rel_cnt_q - CW'(1);
            end
            S_RUN: begin
                we_c = bus.wr_en;
                if (bus.ld_reload) begin
                    state_d    = S_LOAD;
                    ld_count_d = 16'h0000;
                    ld_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the state being entered
        cpu_resetn_d = (state_d == S_RUN);
        running_d    = (state_d == S_RUN);
        ld_ready_d   = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rel_cnt_q    <= '0;
            ld_count_q   <= 16'h0000;
            ld_err_q     <= 1'b0;
            cpu_resetn_q <= 1'b0;
            ld_ready_q   <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rel_cnt_q    <= rel_cnt_d;
            ld_count_q   <= ld_count_d;
            ld_err_q     <= ld_err_d;
            cpu_resetn_q <= cpu_resetn_d;
            ld_ready_q   <= ld_ready_d;
            running_q    <= running_d;
        end
    end

    // Vector file restores its power-on contents on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) vec_q[i] <= 8'h00;
            vec_q[2] <= RESET_VECTOR[7:0];
            vec_q[3] <= RESET_VECTOR[15:8];
        end else if (we_c && is_vec(waddr_c)) begin
            vec_q[3'(waddr_c - VEC_BASE)] <= wdata_c;
        end
    end

    // RAM has no reset so a partial load survives an abort
    always_ff @(posedge clk) begin
        if (we_c && is_ram(waddr_c)) ram_q[RAM_AW'(waddr_c)] <= wdata_c;
    end

    assign bus.cpu_resetn = cpu_resetn_q;
    assign bus.ld_ready   = ld_ready_q;
    assign bus.ld_count   = ld_count_q;
    assign bus.ld_err     = ld_err_q;
    assign bus.running    = running_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, loads, release timing, RUN accesses, reload.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .RAM_AW(12),
        .RESET_VECTOR(16'h0200),
        .RELEASE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus.address = a;
        #1;
        chk16(name, {8'h00, bus.rd_data}, {8'h00, exp});
    endtask

    task automatic ld(input logic [15:0] a, input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        bus.ld_last  = last;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk1({tag, "_cpu_resetn"}, bus.cpu_resetn, 1'b0);
        chk1({tag, "_ld_ready"}, bus.ld_ready, 1'b0);
        chk16({tag, "_ld_count"}, bus.ld_count, 16'h0000);
        chk1({tag, "_ld_err"}, bus.ld_err, 1'b0);
        chk1({tag, "_running"}, bus.running, 1'b0);
    endtask

    task automatic add(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input logic c, input logic [7:0] e);
        tbl.push_back('{a, w, d, c, e});
    endtask

    initial begin
        // RUN-mode access table: {address, wr_en, wr_data, check, expected rd_data}
        add(16'h0200, 1'b0, 8'h00, 1'b1, 8'hA9);
        add(16'h0202, 1'b0, 8'h00, 1'b1, 8'hEA);
        add(16'hFFFC, 1'b0, 8'h00, 1'b1, 8'h00);
        add(16'hFFFD, 1'b0, 8'h00, 1'b1, 8'h02);
        add(16'h0100, 1'b1, 8'h5A, 1'b1, 8'h33);
        add(16'h0100, 1'b0, 8'h00, 1'b1, 8'h5A);
        add(16'h0010, 1'b1, 8'h5A, 1'b0, 8'h00);
        add(16'h0010, 1'b0, 8'h00, 1'b1, 8'h5A);
        add(16'hFFFE, 1'b1, 8'h77, 1'b1, 8'h00);
        add(16'hFFFE, 1'b0, 8'h00, 1'b1, 8'h77);
        add(16'h5000, 1'b1, 8'h12, 1'b1, 8'hFF);
        add(16'h5000, 1'b0, 8'h00, 1'b1, 8'hFF);
        add(16'h0FFF, 1'b1, 8'h44, 1'b0, 8'h00);
        add(16'h0FFF, 1'b0, 8'h00, 1'b1, 8'h44);
        add(16'h1000, 1'b0, 8'h00, 1'b1, 8'hFF);
        add(16'hFFF9, 1'b0, 8'h00, 1'b1, 8'hFF);
        add(16'hFFFA, 1'b0, 8'h00, 1'b1, 8'h00);
        add(16'hFFFB, 1'b0, 8'h00, 1'b1, 8'h00);
        add(16'h0201, 1'b0, 8'h00, 1'b1, 8'h05);

        reset         = 1'b1;
        bus.address   = 16'h0000;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = 16'h0000;
        bus.ld_data   = 8'h00;
        bus.ld_last   = 1'b0;
        bus.ld_reload = 1'b0;
        repeat (2) @(negedge clk);

        chk_reset_outs("por");
        rd_chk("por_vec_fffc", 16'hFFFC, 8'h00);
        rd_chk("por_vec_fffd", 16'hFFFD, 8'h02);
        rd_chk("por_unmapped", 16'h8000, 8'hFF);

        reset = 1'b0;
        #1;
        chk1("idle_ld_ready", bus.ld_ready, 1'b0);
        @(negedge clk);
        chk1("load_ld_ready", bus.ld_ready, 1'b1);
        chk1("load_cpu_resetn", bus.cpu_resetn, 1'b0);

        // Load A: unmapped byte, then a RAM byte, then reset mid-load
        ld(16'h5000, 8'h77, 1'b0);
        chk1("ldA_err", bus.ld_err, 1'b1);
        chk16("ldA_count1", bus.ld_count, 16'd1);
        rd_chk("ldA_5000", 16'h5000, 8'hFF);
        ld(16'h0100, 8'h33, 1'b0);
        chk16("ldA_count2", bus.ld_count, 16'd2);
        reset = 1'b1;
        #1;
        chk_reset_outs("midload");
        rd_chk("midload_ram_kept", 16'h0100, 8'h33);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("reload_ld_ready", bus.ld_ready, 1'b1);

        // Load B: program bytes; core write during LOAD must be ignored
        ld(16'h0200, 8'hA9, 1'b0);
        bus.wr_en   = 1'b1;
        bus.address = 16'h0200;
        bus.wr_data = 8'h99;
        ld(16'h0201, 8'h05, 1'b0);
        bus.wr_en   = 1'b0;
        bus.ld_last = 1'b1;
        @(negedge clk);
        bus.ld_last = 1'b0;
        chk1("last_novalid_ready", bus.ld_ready, 1'b1);
        chk16("last_novalid_count", bus.ld_count, 16'd2);
        ld(16'h0202, 8'hEA, 1'b1);
        chk1("ldB_ready_drop", bus.ld_ready, 1'b0);
        chk16("ldB_count", bus.ld_count, 16'd3);
        chk1("ldB_rel0_resetn", bus.cpu_resetn, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk1($sformatf("ldB_rel%0d_resetn", i), bus.cpu_resetn, i == 4);
        end
        chk1("ldB_running", bus.running, 1'b1);

        // RUN: table of reads/writes, loader activity must be ignored
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 16'h0201;
        bus.ld_data  = 8'hFF;
        bus.ld_last  = 1'b1;
        foreach (tbl[i]) begin
            bus.address = tbl[i].addr;
            bus.wr_en   = tbl[i].we;
            bus.wr_data = tbl[i].wdata;
            #1;
            if (tbl[i].chk)
                chk16($sformatf("run_tbl%0d_%h", i, tbl[i].addr),
                      {8'h00, bus.rd_data}, {8'h00, tbl[i].exp});
            @(negedge clk);
        end
        bus.wr_en    = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk16("run_count_held", bus.ld_count, 16'd3);
        chk1("run_err_clear", bus.ld_err, 1'b0);

        // Reload with a concurrent core write
        bus.ld_reload = 1'b1;
        bus.address   = 16'h0011;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 8'h66;
        @(negedge clk);
        bus.ld_reload = 1'b0;
        bus.wr_en     = 1'b0;
        chk1("rl1_cpu_resetn", bus.cpu_resetn, 1'b0);
        chk1("rl1_running", bus.running, 1'b0);
        chk1("rl1_ld_ready", bus.ld_ready, 1'b1);
        chk16("rl1_ld_count", bus.ld_count, 16'd0);
        rd_chk("rl1_wr_done", 16'h0011, 8'h66);

        // Load C: new reset vector plus an unmapped byte
        ld(16'hFFFC, 8'h00, 1'b0);
        ld(16'h5000, 8'h88, 1'b0);
        chk1("ldC_err", bus.ld_err, 1'b1);
        chk16("ldC_count2", bus.ld_count, 16'd2);
        rd_chk("ldC_5000", 16'h5000, 8'hFF);
        ld(16'hFFFD, 8'h03, 1'b1);
        chk16("ldC_count3", bus.ld_count, 16'd3);
        repeat (4) @(negedge clk);
        chk1("ldC_cpu_resetn", bus.cpu_resetn, 1'b1);
        chk1("ldC_running", bus.running, 1'b1);
        chk1("ldC_err_held", bus.ld_err, 1'b1);
        rd_chk("ldC_vec_lo", 16'hFFFC, 8'h00);
        rd_chk("ldC_vec_hi", 16'hFFFD, 8'h03);

        // Second reload clears the sticky error
        bus.ld_reload = 1'b1;
        @(negedge clk);
        bus.ld_reload = 1'b0;
        chk1("rl2_ld_err", bus.ld_err, 1'b0);
        chk16("rl2_ld_count", bus.ld_count, 16'd0);
        chk1("rl2_cpu_resetn", bus.cpu_resetn, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
